// File: rtl/rv32i_types.sv
// Shared types for the instruction-fetch front end.
//   fetch_state_t : prefetch controller states
//   INSTR_BYTES   : size of one instruction word in bytes
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue with synchronous flush.
//   clk, rst_n : clock, async active-low reset
//   flush      : empties the queue and rewinds both pointers (wins over push/pop)
//   push/wdata : write one entry at the write pointer
//   pop        : advance the read pointer
//   rdata      : entry at the read pointer (registered storage, no bypass)
//   count      : current occupancy, 0..DEPTH
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: keeps a small queue of fetched words ahead of decode,
// with one outstanding read on memory port A and flush-and-refetch on redirect.
//   clk, rst_n                    : clock, async active-low reset
//   read_a/address_a/resp_a/rdata_a : memory port A
//   instr_valid/instr/instr_pc/instr_ready : queue head handshake to decode
//   redirect/redirect_pc          : flush queue and restart fetch at redirect_pc
//
// state | meaning
// IDLE  | no request outstanding
// REQ   | request outstanding, response will be queued
// DRAIN | stale request outstanding, response will be dropped
module if_prefetch
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        read_a,
    output logic [31:0] address_a,
    input  logic        resp_a,
    input  logic [31:0] rdata_a,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;

    logic [CW-1:0] count;
    logic [CW-1:0] cnt_next;
    logic [63:0]   head;
    logic          push, pop, slot_free;
    logic [31:0]   redir_pc, pc_inc;

    assign redir_pc    = redirect_pc & ~(32'(INSTR_BYTES) - 32'd1);
    assign pc_inc      = fetch_pc_q + 32'(INSTR_BYTES);
    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign push        = (state_q == REQ) & resp_a & ~redirect;

    // Occupancy after this edge; a new request may only go out if it will
    // still have a slot, so push can never overflow.
    assign cnt_next  = redirect ? '0 : count + CW'(push) - CW'(pop);
    assign slot_free = (cnt_next < CW'(DEPTH));

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .wdata ({req_addr_q, rdata_a}),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    assign instr    = head[31:0];
    assign instr_pc = head[63:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        case (state_q)
            IDLE: begin
                // A redirect here only moves the PC; the request follows next cycle.
                if (redirect) begin
                    fetch_pc_d = redir_pc;
                end else if (slot_free) begin
                    state_d    = REQ;
                    req_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redir_pc;
                    if (resp_a) begin
                        // Response dropped; queue is empty so refetch at once.
                        state_d    = REQ;
                        req_addr_d = redir_pc;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (resp_a) begin
                    fetch_pc_d = pc_inc;
                    if (slot_free) begin
                        req_addr_d = pc_inc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = redir_pc;
                end
                if (resp_a) begin
                    if (slot_free) begin
                        state_d    = REQ;
                        req_addr_d = fetch_pc_d;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        read_a = (state_q == REQ) || (state_q == DRAIN);
    end

    assign address_a = req_addr_q;

endmodule
